// File: rtl/bus_copy_engine_pkg.sv
// Shared definitions for the bus copy engine: FSM states, error codes and
// byte-select encodings of the valid/ready memory interface.
package bus_copy_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    localparam logic [3:0] WSEL_READ = 4'h0;
    localparam logic [3:0] WSEL_WORD = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/bus_copy_engine_watchdog.sv
// Request watchdog for bus masters: flags expiry on the TIMEOUT-th consecutive
// cycle a request waits without ready. TIMEOUT=0 disables it.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic waiting,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A ready in the expiry cycle clears waiting, so the completion wins.
    assign expired = (TIMEOUT != 0) && waiting && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_copy_engine.sv
// Secondary bus master that copies len words from src_addr to dst_addr using
// alternating read/write requests; reports done, sticky error and progress.
module bus_copy_engine
    import bus_copy_engine_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       error_code,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wsel,
    output logic             mem_valid,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic             mem_error
);

    state_e           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [31:0]      buffer_q, buffer_d;
    logic [LEN_W-1:0] remaining_q, remaining_d, words_done_q, words_done_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    err_e             err_code_q, err_code_d;
    logic [31:0]      mem_address_q, mem_address_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wsel_q, mem_wsel_d;
    logic             mem_valid_q, mem_valid_d;
    logic             handshake, wd_restart, wd_waiting, expired;

    assign handshake  = mem_valid_q && mem_ready;
    assign wd_restart = !mem_valid_q || mem_ready;
    assign wd_waiting = mem_valid_q && !mem_ready;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (wd_restart),
        .waiting (wd_waiting),
        .expired (expired)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        buffer_d     = buffer_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_ptr_d    = word_align(src_addr);
                    dst_ptr_d    = word_align(dst_addr);
                    remaining_d  = len;
                    words_done_d = '0;
                    error_d      = 1'b0;
                    err_code_d   = ERR_NONE;
                    state_d      = (len == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                if (handshake) begin
                    if (mem_error) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_BUS;
                        state_d    = ST_FINISH;
                    end else begin
                        buffer_d = mem_rdata;
                        state_d  = ST_WRITE;
                    end
                end else if (expired) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_FINISH;
                end
            end
            ST_WRITE: begin
                if (handshake) begin
                    if (mem_error) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_BUS;
                        state_d    = ST_FINISH;
                    end else begin
                        src_ptr_d    = src_ptr_q + 32'd4;
                        dst_ptr_d    = dst_ptr_q + 32'd4;
                        words_done_d = words_done_q + 1'b1;
                        remaining_d  = remaining_q - 1'b1;
                        state_d      = (remaining_q == LEN_W'(1)) ? ST_FINISH : ST_READ;
                    end
                end else if (expired) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they belong to.
        mem_valid_d   = (state_d == ST_READ) || (state_d == ST_WRITE);
        mem_address_d = '0;
        mem_wdata_d   = '0;
        mem_wsel_d    = WSEL_READ;
        if (state_d == ST_READ) begin
            mem_address_d = src_ptr_d;
        end else if (state_d == ST_WRITE) begin
            mem_address_d = dst_ptr_d;
            mem_wdata_d   = buffer_d;
            mem_wsel_d    = WSEL_WORD;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    // NOTE: state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            src_ptr_q     <= '0;
            dst_ptr_q     <= '0;
            buffer_q      <= '0;
            remaining_q   <= '0;
            words_done_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_wsel_q    <= WSEL_READ;
            mem_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_ptr_q     <= src_ptr_d;
            dst_ptr_q     <= dst_ptr_d;
            buffer_q      <= buffer_d;
            remaining_q   <= remaining_d;
            words_done_q  <= words_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wsel_q    <= mem_wsel_d;
            mem_valid_q   <= mem_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign error_code  = err_code_q;
    assign words_done  = words_done_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wsel    = mem_wsel_q;
    assign mem_valid   = mem_valid_q;

endmodule

// File: tb/tb_bus_copy_engine.sv
// Bench for bus_copy_engine: a RAM responder with random ready/error, and a
// transaction-list model of each copy job checked on every request cycle.
module tb_bus_copy_engine;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, error;
    logic [1:0]       error_code;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      mem_address, mem_wdata;
    logic [3:0]       mem_wsel;
    logic             mem_valid;
    logic [31:0]      mem_rdata = '0;
    logic             mem_ready = 1'b0;
    logic             mem_error = 1'b0;

    bus_copy_engine #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_code  (error_code),
        .words_done  (words_done),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wsel    (mem_wsel),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_error   (mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] obs_addr[$];
    logic [31:0] ram       [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    int n_checks = 0;
    int n_err = 0;
    int cycle = 0;
    int ready_pct = 100;
    bit never_ready = 1'b0;
    int err_at = -1;
    int txn_idx = 0;
    int last_hs_cycle = 0;
    int wait_run = 0;
    int max_wait_run = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : (32'hA5A5_0000 ^ a);
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Responder and per-cycle request checker.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = $urandom;
        if (rst_n && done) done_cnt++;
        if (rst_n && mem_valid) begin
            check("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("req_addr", mem_address, exp_q[0].addr);
                check("req_wsel", 32'(mem_wsel), exp_q[0].wr ? 32'hF : 32'h0);
                if (exp_q[0].wr) check("req_wdata", mem_wdata, exp_q[0].data);
                mem_ready = !never_ready &&
                            (wait_run >= 5 || $urandom_range(0, 99) < 32'(ready_pct));
                if (mem_ready) begin
                    mem_error = (txn_idx == err_at);
                    if (!exp_q[0].wr) mem_rdata = ram_rd(mem_address);
                    else if (!mem_error) ram[mem_address] = mem_wdata;
                    obs_addr.push_back(mem_address);
                    last_hs_cycle = cycle;
                    txn_idx++;
                    wait_run = 0;
                    if (mem_error) exp_q.delete();
                    else void'(exp_q.pop_front());
                end else begin
                    wait_run++;
                    if (wait_run > max_wait_run) max_wait_run = wait_run;
                end
            end
        end else begin
            wait_run = 0;
        end
    end

    // Expected job as a flat list of bus transactions plus final memory image.
    task automatic build_model(input logic [31:0] s, input logic [31:0] d, input int l);
        logic [31:0] ps, pd, v;
        model_mem.delete();
        exp_q.delete();
        ps = s & 32'hFFFF_FFFC;
        pd = d & 32'hFFFF_FFFC;
        for (int i = 0; i < l; i++) begin
            v = model_mem.exists(ps) ? model_mem[ps] : ram_rd(ps);
            exp_q.push_back('{addr: ps, wr: 1'b0, data: 32'h0});
            exp_q.push_back('{addr: pd, wr: 1'b1, data: v});
            model_mem[pd] = v;
            ps += 32'd4;
            pd += 32'd4;
        end
    endtask

    task automatic check_dst();
        foreach (model_mem[a]) check("dst_word", ram_rd(a), model_mem[a]);
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int l);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(l);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_code"}, 32'(error_code), 32'd0);
        check({tag, "_words"}, 32'(words_done), 32'd0);
        check({tag, "_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_addr"}, mem_address, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_wsel"}, 32'(mem_wsel), 32'd0);
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int l,
                           input int err, input int rp, input bit nr);
        int k;
        int done_cycle;
        build_model(s, d, l);
        obs_addr.delete();
        txn_idx      = 0;
        err_at       = err;
        ready_pct    = rp;
        never_ready  = nr;
        done_cnt     = 0;
        max_wait_run = 0;
        pulse_start(s, d, l);
        check("busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        done_cycle = cycle;
        check("valid_low_in_done", 32'(mem_valid), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        if (l != 0 && !nr) check("done_latency", 32'(done_cycle), 32'(last_hs_cycle + 1));
        if (err < 0 && !nr) check("all_txns_done", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        exp_q.delete();
        never_ready = 1'b0;
        err_at      = -1;
    endtask

    initial begin
        logic [31:0] s, d;
        int l, e, rp, k;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic copy with single-cycle ready.
        for (int i = 0; i < 4; i++) ram[32'h100 + 32'(4 * i)] = 32'h1000_0000 + 32'(i);
        run_job(32'h100, 32'h200, 4, -1, 100, 1'b0);
        check("basic_words", 32'(words_done), 32'd4);
        check("basic_error", 32'(error), 32'd0);
        check("basic_code", 32'(error_code), 32'd0);
        check("basic_ntxn", 32'(obs_addr.size()), 32'd8);
        check("basic_addr1", obs_addr[1], 32'h200);
        check("basic_addr7", obs_addr[7], 32'h20C);
        check("basic_last_word", ram_rd(32'h20C), 32'h1000_0003);
        check_dst();

        // Bus error on the second read.
        run_job(32'h1000, 32'h2000, 3, 2, 100, 1'b0);
        check("buserr_error", 32'(error), 32'd1);
        check("buserr_code", 32'(error_code), 32'd1);
        check("buserr_words", 32'(words_done), 32'd1);
        check("buserr_ntxn", 32'(obs_addr.size()), 32'd3);

        // Zero-length job: no bus activity, clears the sticky error.
        run_job(32'h5000, 32'h6000, 0, -1, 100, 1'b0);
        check("len0_error", 32'(error), 32'd0);
        check("len0_code", 32'(error_code), 32'd0);
        check("len0_words", 32'(words_done), 32'd0);
        check("len0_ntxn", 32'(obs_addr.size()), 32'd0);

        // Responder never readies.
        run_job(32'h3000, 32'h4000, 2, -1, 100, 1'b1);
        check("timeout_wait", 32'(max_wait_run), 32'(TIMEOUT));
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_code", 32'(error_code), 32'd2);
        check("timeout_words", 32'(words_done), 32'd0);

        // Source pointer wraps past the top of the address space.
        run_job(32'hFFFF_FFFE, 32'h800, 2, -1, 100, 1'b0);
        check("wrap_addr0", obs_addr[0], 32'hFFFF_FFFC);
        check("wrap_addr2", obs_addr[2], 32'h0);
        check("wrap_words", 32'(words_done), 32'd2);
        check_dst();

        // A start pulse during a job is ignored.
        fork
            run_job(32'h1100, 32'h2100, 3, -1, 100, 1'b0);
            begin
                repeat (4) @(negedge clk);
                src_addr = 32'h9000;
                len      = LEN_W'(7);
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("ignore_words", 32'(words_done), 32'd3);
        check("ignore_ntxn", 32'(obs_addr.size()), 32'd6);
        repeat (3) @(negedge clk);
        check("ignore_idle", 32'(busy), 32'd0);

        // Asynchronous reset during a write, then a clean job.
        build_model(32'h300, 32'h400, 3);
        obs_addr.delete();
        txn_idx   = 0;
        ready_pct = 50;
        pulse_start(32'h300, 32'h400, 3);
        k = 0;
        while (!(mem_valid && mem_wsel == 4'hF) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("midwrite_seen", 32'(mem_valid && mem_wsel == 4'hF), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("reset_held_valid", 32'(mem_valid), 32'd0);
        rst_n = 1'b1;
        run_job(32'h300, 32'h400, 3, -1, 100, 1'b0);
        check("post_reset_words", 32'(words_done), 32'd3);
        check("post_reset_error", 32'(error), 32'd0);
        check_dst();

        // Randomized jobs with random ready timing and occasional bus errors.
        for (int j = 0; j < 12; j++) begin
            s  = $urandom;
            d  = $urandom;
            l  = int'($urandom_range(1, 6));
            rp = int'($urandom_range(40, 100));
            e  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(2 * l - 1))) : -1;
            run_job(s, d, l, e, rp, 1'b0);
            if (e < 0) begin
                check("rand_words", 32'(words_done), 32'(l));
                check("rand_error", 32'(error), 32'd0);
                check("rand_code", 32'(error_code), 32'd0);
                check_dst();
            end else begin
                check("rand_err_words", 32'(words_done), 32'(e / 2));
                check("rand_err_error", 32'(error), 32'd1);
                check("rand_err_code", 32'(error_code), 32'd1);
                check("rand_err_ntxn", 32'(obs_addr.size()), 32'(e + 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
